// File: rtl/mem_writeback_stage.sv
// Final pipeline stage: performs data-memory stores over a req/ack handshake,
// then the register-file write, holding the upstream ALU-result register via busy.
module mem_writeback_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [REG_ADDR_W-1:0] in_reg_num,
  input  logic                  in_reg_enable,
  input  logic                  in_mem_enable,
  output logic                  busy,
  output logic                  mem_req,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] WB       = 2'd2;

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_W-1:0]     lat_data;
  logic [REG_ADDR_W-1:0] lat_reg_num;
  logic                  lat_reg_en;
  logic                  wb_pending;
  logic                  store_done;

  // Register writes to r0 are suppressed, so a store with reg_num 0 returns to IDLE.
  assign wb_pending = lat_reg_en && (lat_reg_num != '0);
  assign store_done = mem_ack || (wait_cnt == CNT_LAST);

  // busy is kept equal to (state != IDLE) by updating it alongside every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_data     <= '0;
      lat_reg_num  <= '0;
      lat_reg_en   <= 1'b0;
      busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            lat_data    <= in_data;
            lat_reg_num <= in_reg_num;
            lat_reg_en  <= in_reg_enable;
            if (in_mem_enable && (in_mem_addr[1:0] == 2'b00)) begin
              state     <= MEM_WAIT;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_addr  <= {in_mem_addr[DATA_W-1:2], 2'b00};
              mem_wdata <= in_data;
            end else begin
              if (in_mem_enable) begin
                misalign_err <= 1'b1;
              end
              if (in_reg_enable && (in_reg_num != '0)) begin
                state    <= WB;
                busy     <= 1'b1;
                rf_we    <= 1'b1;
                rf_waddr <= in_reg_num;
                rf_wdata <= in_data;
              end
            end
          end
        end
        MEM_WAIT: begin
          if (store_done) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            // An ack arriving on the timeout edge still counts as success.
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
            if (wb_pending) begin
              state    <= WB;
              rf_we    <= 1'b1;
              rf_waddr <= lat_reg_num;
              rf_wdata <= lat_data;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_req  <= 1'b0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed self-checking bench for mem_writeback_stage: register writeback,
// store handshake, timeout, misalignment, busy hold-off and mid-store reset.
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_mem_addr;
  logic [4:0]  in_reg_num;
  logic        in_reg_enable;
  logic        in_mem_enable;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int req_cycles;
  int overlap;

  always #5 clk = ~clk;

  mem_writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_mem_addr   (in_mem_addr),
    .in_reg_num    (in_reg_num),
    .in_reg_enable (in_reg_enable),
    .in_mem_enable (in_mem_enable),
    .busy          (busy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic [31:0] addr, input logic [4:0] reg_num,
                               input logic reg_en, input logic mem_en);
    in_valid      = valid;
    in_data       = data;
    in_mem_addr   = addr;
    in_reg_num    = reg_num;
    in_reg_enable = reg_en;
    in_mem_enable = mem_en;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Counts mem_req-high cycles of an outstanding store, raising mem_ack on
  // cycle ack_at (0 = never), and records any cycle where rf_we overlaps mem_req.
  task automatic runStore(input int ack_at);
    req_cycles = 0;
    overlap    = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      if (rf_we) overlap++;
      mem_ack = (ack_at != 0) && (req_cycles == ack_at);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset_rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("reset_errs", {30'b0, misalign_err, timeout_err}, 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);

    // 1: register-only writeback one cycle after accept
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h0, 5'd7, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("t1_rf_we", {31'b0, rf_we}, 32'd1);
    checkOutput("t1_waddr", {27'b0, rf_waddr}, 32'd7);
    checkOutput("t1_wdata", rf_wdata, 32'hDEADBEEF);
    checkOutput("t1_busy", {31'b0, busy}, 32'd1);
    checkOutput("t1_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    checkOutput("t1_we_pulse", {31'b0, rf_we}, 32'd0);
    checkOutput("t1_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("t1_waddr_hold", {27'b0, rf_waddr}, 32'd7);

    // 2: store then register write, ack on third request cycle
    applyStimulus(1'b1, 32'h55, 32'h100, 5'd3, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("t2_req", {31'b0, mem_req}, 32'd1);
    checkOutput("t2_addr", mem_addr, 32'h100);
    checkOutput("t2_wdata", mem_wdata, 32'h55);
    runStore(3);
    checkOutput("t2_req_cycles", req_cycles, 32'd3);
    checkOutput("t2_overlap", overlap, 32'd0);
    checkOutput("t2_rf_we", {31'b0, rf_we}, 32'd1);
    checkOutput("t2_waddr", {27'b0, rf_waddr}, 32'd3);
    checkOutput("t2_rf_wdata", rf_wdata, 32'h55);
    checkOutput("t2_busy_wb", {31'b0, busy}, 32'd1);
    tick();
    checkOutput("t2_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("t2_no_timeout", {31'b0, timeout_err}, 32'd0);

    // 3: store never acked times out after 16 request cycles
    applyStimulus(1'b1, 32'h11, 32'h40, 5'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    runStore(0);
    checkOutput("t3_req_cycles", req_cycles, 32'd16);
    checkOutput("t3_timeout_err", {31'b0, timeout_err}, 32'd1);
    checkOutput("t3_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("t3_no_rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("t3_no_misalign", {31'b0, misalign_err}, 32'd0);

    // 4: misaligned store dropped, register write still happens
    applyStimulus(1'b1, 32'h99, 32'h102, 5'd9, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("t4_no_req", {31'b0, mem_req}, 32'd0);
    checkOutput("t4_misalign", {31'b0, misalign_err}, 32'd1);
    checkOutput("t4_rf_we", {31'b0, rf_we}, 32'd1);
    checkOutput("t4_waddr", {27'b0, rf_waddr}, 32'd9);
    tick();
    checkOutput("t4_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("t4_timeout_sticky", {31'b0, timeout_err}, 32'd1);

    // 5a: write to register 0 is a nop
    applyStimulus(1'b1, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("t5_r0_no_we", {31'b0, rf_we}, 32'd0);
    checkOutput("t5_r0_not_busy", {31'b0, busy}, 32'd0);

    // 5b: second instruction held while busy is accepted exactly once afterwards
    applyStimulus(1'b1, 32'hA, 32'h200, 5'd4, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'hB, 32'h0, 5'd5, 1'b1, 1'b0);
    checkOutput("t5_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("t5_first_we", {31'b0, rf_we}, 32'd1);
    checkOutput("t5_first_waddr", {27'b0, rf_waddr}, 32'd4);
    checkOutput("t5_first_wdata", rf_wdata, 32'hA);
    tick();
    checkOutput("t5_gap_we", {31'b0, rf_we}, 32'd0);
    checkOutput("t5_gap_busy", {31'b0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("t5_second_we", {31'b0, rf_we}, 32'd1);
    checkOutput("t5_second_waddr", {27'b0, rf_waddr}, 32'd5);
    checkOutput("t5_second_wdata", rf_wdata, 32'hB);
    tick();
    checkOutput("t5_once", {31'b0, rf_we}, 32'd0);
    checkOutput("t5_idle", {31'b0, busy}, 32'd0);

    // 6: reset in the middle of an outstanding store
    applyStimulus(1'b1, 32'h66, 32'h300, 5'd6, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("t6_req", {31'b0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_req_low", {31'b0, mem_req}, 32'd0);
    checkOutput("t6_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("t6_errs_clear", {30'b0, misalign_err, timeout_err}, 32'd0);
    checkOutput("t6_addr_clear", mem_addr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t6_no_rf_we", {31'b0, rf_we}, 32'd0);
      checkOutput("t6_no_req", {31'b0, mem_req}, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
